// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int N_CH_DEFAULT    = 4;
  localparam int DIV_W_DEFAULT   = 8;
  localparam int DIV_RST_DEFAULT = 4;

  // A programmed ratio of zero behaves as divide-by-one.
  function automatic logic [31:0] eff_div(input logic [31:0] n);
    return (n == 32'd0) ? 32'd1 : n;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/staged ratio, tick and 50% divided clock.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEFAULT,
  parameter int DIV_RST = DIV_RST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             pending,
  output logic             tick,
  output logic             div_clk
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic [DIV_W-1:0] staged_q, staged_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             div_clk_q, div_clk_d;
  logic [31:0]      term_cnt;
  logic             at_term;
  logic             apply;

  // Compared in 32 bits so the zero-to-one mapped ratio never wraps.
  assign term_cnt = eff_div(32'(active_q)) - 32'd1;
  assign at_term  = (32'(cnt_q) == term_cnt);

  always_comb begin
    cnt_d     = cnt_q;
    active_d  = active_q;
    staged_d  = staged_q;
    pending_d = pending_q;
    tick_d    = 1'b0;
    div_clk_d = div_clk_q;
    apply     = 1'b0;
    if (!en || sync) begin
      cnt_d     = '0;
      div_clk_d = 1'b0;
      apply     = pending_q;
    end else if (at_term) begin
      cnt_d     = '0;
      tick_d    = 1'b1;
      div_clk_d = ~div_clk_q;
      apply     = pending_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    if (apply) begin
      active_d  = staged_q;
      pending_d = 1'b0;
    end
    // A new load only arrives while nothing is pending, so it never collides with apply.
    if (load) begin
      staged_d  = load_div;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      active_q  <= DIV_W'(DIV_RST);
      staged_q  <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      div_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      staged_q  <= staged_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      div_clk_q <= div_clk_d;
    end
  end

  assign pending = pending_q;
  assign tick    = tick_q;
  assign div_clk = div_clk_q;

endmodule

// File: rtl/clk_div_gen.sv
// Array of independent programmable clock dividers with a shared ratio-update port.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int  N_CH    = N_CH_DEFAULT,
  parameter int  DIV_W   = DIV_W_DEFAULT,
  parameter int  DIV_RST = DIV_RST_DEFAULT,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             sync,
  input  logic             cfg_valid,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic [N_CH-1:0]  cfg_pending,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  div_clk
);

  logic [N_CH-1:0] load;

  // Out-of-range channel selects match nothing: always ready, request dropped.
  always_comb begin
    cfg_ready = 1'b1;
    load      = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (32'(cfg_ch) == 32'(i)) begin
        cfg_ready = !cfg_pending[i];
        load[i]   = cfg_valid && !cfg_pending[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_channel #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (ch_en[g]),
      .sync     (sync),
      .load     (load[g]),
      .load_div (cfg_div),
      .pending  (cfg_pending[g]),
      .tick     (tick[g]),
      .div_clk  (div_clk[g])
    );
  end

endmodule
